// File: rtl/day11_sr_latch.sv
// ============================================================================
// Module   : day11_sr_latch
// Purpose  : Clocked SR storage element, WIDTH independent bits, with true and
//            complementary outputs and per-bit flags for the S=R=1 input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module day11_sr_latch #(
    parameter int WIDTH        = 1,
    parameter int INVALID_MODE = 0,
    parameter int STICKY_ERR   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] invalid,
    output logic             err_sticky
);

    logic [WIDTH-1:0] w_set_only;
    logic [WIDTH-1:0] w_clr_only;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_set_eff;
    logic [WIDTH-1:0] w_clr_eff;
    logic [WIDTH-1:0] w_out_mask;
    logic [WIDTH-1:0] w_state_nxt;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic [WIDTH-1:0] r_invalid;

    assign w_set_only = s & ~r;
    assign w_clr_only = r & ~s;
    assign w_both     = s & r;

    // The S=R=1 case is folded into the effective set/clear terms; in NOR
    // style neither fires (state preserved) and both outputs are forced low.
    generate
        if (INVALID_MODE == 1) begin : g_set_wins
            assign w_set_eff  = s;
            assign w_clr_eff  = w_clr_only;
            assign w_out_mask = '0;
        end else if (INVALID_MODE == 2) begin : g_reset_wins
            assign w_set_eff  = w_set_only;
            assign w_clr_eff  = r;
            assign w_out_mask = '0;
        end else begin : g_nor_style
            assign w_set_eff  = w_set_only;
            assign w_clr_eff  = w_clr_only;
            assign w_out_mask = w_both;
        end
    endgenerate

    assign w_state_nxt = (r_state | w_set_eff) & ~w_clr_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= '0;
            r_q       <= '0;
            r_qbar    <= '1;
            r_invalid <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_state_nxt & ~w_out_mask;
            r_qbar    <= ~w_state_nxt & ~w_out_mask;
            r_invalid <= w_both;
        end
    end

    generate
        if (STICKY_ERR != 0) begin : g_sticky
            logic r_err_sticky;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_err_sticky <= 1'b0;
                end else begin
                    r_err_sticky <= r_err_sticky | (|w_both);
                end
            end
            assign err_sticky = r_err_sticky;
        end else begin : g_no_sticky
            assign err_sticky = 1'b0;
        end
    endgenerate

    assign q       = r_q;
    assign qbar    = r_qbar;
    assign invalid = r_invalid;

endmodule

`default_nettype wire

// File: tb/tb_day11_sr_latch.sv
// ============================================================================
// Module   : tb_day11_sr_latch
// Purpose  : Scoreboard bench for day11_sr_latch across all three S=R=1 modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_day11_sr_latch;

    localparam int W = 4;

    typedef struct {
        logic [2:0][W-1:0] q;
        logic [2:0][W-1:0] qb;
        logic [2:0][W-1:0] inv;
        logic [2:0]        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;

    logic [W-1:0] q_o   [3];
    logic [W-1:0] qb_o  [3];
    logic [W-1:0] inv_o [3];
    logic         err_o [3];

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail = 0;

    // reference state: one stored bit per instance per bit, plus sticky flag
    int           m_state [3][W];
    int           m_err   [3];
    int           modes   [3] = '{0, 1, 2};
    int           stickys [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    day11_sr_latch #(.WIDTH(W), .INVALID_MODE(0), .STICKY_ERR(1)) u_mode0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r),
        .q(q_o[0]), .qbar(qb_o[0]), .invalid(inv_o[0]), .err_sticky(err_o[0]));
    day11_sr_latch #(.WIDTH(W), .INVALID_MODE(1), .STICKY_ERR(0)) u_mode1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r),
        .q(q_o[1]), .qbar(qb_o[1]), .invalid(inv_o[1]), .err_sticky(err_o[1]));
    day11_sr_latch #(.WIDTH(W), .INVALID_MODE(2), .STICKY_ERR(1)) u_mode2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r),
        .q(q_o[2]), .qbar(qb_o[2]), .invalid(inv_o[2]), .err_sticky(err_o[2]));

    task automatic chk(input string name, input int k, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[mode%0d] at %0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    task automatic apply(input logic rn, input logic [W-1:0] si, input logic [W-1:0] ri);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        s     = si;
        r     = ri;
        for (int k = 0; k < 3; k++) begin
            if (!rn) begin
                for (int b = 0; b < W; b++) m_state[k][b] = 0;
                m_err[k]  = 0;
                e.q[k]    = '0;
                e.qb[k]   = '1;
                e.inv[k]  = '0;
                e.err[k]  = 1'b0;
            end else begin
                for (int b = 0; b < W; b++) begin
                    int invb;
                    invb = 0;
                    if (si[b] && ri[b]) begin
                        invb = 1;
                        if (modes[k] == 1) m_state[k][b] = 1;
                        if (modes[k] == 2) m_state[k][b] = 0;
                    end else if (si[b]) begin
                        m_state[k][b] = 1;
                    end else if (ri[b]) begin
                        m_state[k][b] = 0;
                    end
                    e.inv[k][b] = (invb != 0);
                    if (invb != 0 && modes[k] == 0) begin
                        e.q[k][b]  = 1'b0;
                        e.qb[k][b] = 1'b0;
                    end else begin
                        e.q[k][b]  = (m_state[k][b] != 0);
                        e.qb[k][b] = (m_state[k][b] == 0);
                    end
                end
                if ((si & ri) != '0 && stickys[k] != 0) m_err[k] = 1;
                e.err[k] = (m_err[k] != 0);
            end
        end
        sb.push_back(e);
    endtask

    // monitor: outputs are registered, so every rising edge presents a result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("q",       k, q_o[k],   e.q[k]);
                    chk("qbar",    k, qb_o[k],  e.qb[k]);
                    chk("invalid", k, inv_o[k], e.inv[k]);
                    chk("err_sticky", k, {3'b000, err_o[k]}, {3'b000, e.err[k]});
                end
            end
        end
    end

    initial begin
        int guard;
        // reset, clear, set, hold, forbidden input and recovery
        apply(1'b0, 4'h0, 4'h0);
        apply(1'b0, 4'h0, 4'h0);
        apply(1'b1, 4'h0, 4'h1);
        apply(1'b1, 4'h0, 4'h0);
        apply(1'b1, 4'h1, 4'h0);
        repeat (3) apply(1'b1, 4'h0, 4'h0);
        apply(1'b1, 4'h1, 4'h1);
        apply(1'b1, 4'h0, 4'h0);
        // mixed per-bit patterns from a cleared state
        apply(1'b0, 4'h0, 4'h0);
        apply(1'b1, 4'b0101, 4'b0011);
        apply(1'b1, 4'h0, 4'h0);
        // reset wins over S=R=1, then S=R=1 outside reset
        apply(1'b1, 4'hF, 4'hF);
        apply(1'b0, 4'hF, 4'hF);
        apply(1'b1, 4'h0, 4'h0);
        apply(1'b1, 4'hF, 4'hF);
        apply(1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 31) != 0), W'($urandom), W'($urandom));
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
